sysid_regs: RTL and testbench

SYSID_REGS -- requirements
Module: sysid_regs

---
 rtl/sysid_regs.sv | 116 +++++++++++
 tb/tb_sysid_regs.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_regs.sv
// System ID / timestamp / scratch register block with a pipelined read path.
// Optional 64-bit uptime counter with HI snapshot and CTRL clear: define SYSID_UPTIME_EN.
module sysid_regs #(
   parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP_VALUE = 32'h0000_0000,
   parameter int unsigned READ_LATENCY    = 1,
   parameter int unsigned NUM_SCRATCH     = 2,
   parameter logic [31:0] SCRATCH_INIT    = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        readdatavalid,
   output logic        waitrequest
);

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("sysid_regs: READ_LATENCY must be in 1..4");
   end
   if (NUM_SCRATCH < 1 || NUM_SCRATCH > 4) begin : g_bad_scratch
      $error("sysid_regs: NUM_SCRATCH must be in 1..4");
   end

   localparam logic [2:0] ADDR_ID    = 3'd0;
   localparam logic [2:0] ADDR_TS    = 3'd1;
   localparam logic [2:0] ADDR_UP_LO = 3'd2;
   localparam logic [2:0] ADDR_UP_HI = 3'd3;
   localparam logic [2:0] ADDR_CTRL  = 3'd7;

   logic        rd_accept;
   logic [31:0] rd_mux;
   logic [31:0] scratch [NUM_SCRATCH];

   assign rd_accept   = read & ~write;
   assign waitrequest = 1'b0;

`ifdef SYSID_UPTIME_EN
   logic [63:0] uptime;
   logic [63:0] uptime_nxt;
   logic [31:0] uptime_hi_snap;
   logic        ctrl_clear;

   assign ctrl_clear = write && (address == ADDR_CTRL) && writedata[0];
   assign uptime_nxt = ctrl_clear ? '0 : uptime + 64'd1;

   // Address 2 returns the count as it stands after the accepting edge, so a
   // read directly following a clear sees 1; the snapshot is taken from the same value.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         uptime         <= '0;
         uptime_hi_snap <= '0;
      end else begin
         uptime <= uptime_nxt;
         if (rd_accept && address == ADDR_UP_LO)
            uptime_hi_snap <= uptime_nxt[63:32];
      end
   end
`endif

   // Address 7 always belongs to CTRL, so with NUM_SCRATCH=4 the last scratch is unreachable.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_SCRATCH; i++)
            scratch[i] <= SCRATCH_INIT;
      end else begin
         for (int unsigned i = 0; i < NUM_SCRATCH; i++)
            if (write && address != ADDR_CTRL && address == 3'(4 + i))
               scratch[i] <= writedata;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_ID:    rd_mux = ID_VALUE;
         ADDR_TS:    rd_mux = TIMESTAMP_VALUE;
`ifdef SYSID_UPTIME_EN
         ADDR_UP_LO: rd_mux = uptime_nxt[31:0];
         ADDR_UP_HI: rd_mux = uptime_hi_snap;
         ADDR_CTRL:  rd_mux = 32'd1;
`endif
         default: begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++)
               if (address != ADDR_CTRL && address == 3'(4 + i))
                  rd_mux = scratch[i];
         end
      endcase
   end

   logic [READ_LATENCY-1:0] vld_pipe;
   logic [31:0]             dat_pipe [READ_LATENCY];

   // Stage 0 is loaded at the accepting edge; data is zeroed whenever its valid bit is clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         for (int unsigned i = 0; i < READ_LATENCY; i++)
            dat_pipe[i] <= '0;
      end else begin
         vld_pipe[0] <= rd_accept;
         dat_pipe[0] <= rd_accept ? rd_mux : '0;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            dat_pipe[i] <= dat_pipe[i-1];
         end
      end
   end

   assign readdata      = dat_pipe[READ_LATENCY-1];
   assign readdatavalid = vld_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_regs.sv
// Directed self-checking bench for sysid_regs across four parameterisations on a shared bus.
module tb_sysid_regs;

   localparam logic [31:0] ID    = 32'h037F_5F0C;
   localparam logic [31:0] TS    = 32'h2024_0611;
   localparam logic [31:0] SINIT = 32'hDEAD_BEEF;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  address = '0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = '0;

   logic [31:0] rd1, rd2, rd3, rd4;
   logic        v1, v2, v3, v4;
   logic        w1, w2, w3, w4;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clock = ~clock;

   sysid_regs #(.ID_VALUE(ID), .TIMESTAMP_VALUE(TS), .READ_LATENCY(1), .NUM_SCRATCH(1),
                .SCRATCH_INIT(32'h0000_0000)) u1 (
      .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(rd1), .readdatavalid(v1), .waitrequest(w1));

   sysid_regs #(.ID_VALUE(ID), .TIMESTAMP_VALUE(TS), .READ_LATENCY(2), .NUM_SCRATCH(2),
                .SCRATCH_INIT(32'h0000_0000)) u2 (
      .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(rd2), .readdatavalid(v2), .waitrequest(w2));

   sysid_regs #(.ID_VALUE(ID), .TIMESTAMP_VALUE(TS), .READ_LATENCY(3), .NUM_SCRATCH(2),
                .SCRATCH_INIT(32'h0000_0000)) u3 (
      .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(rd3), .readdatavalid(v3), .waitrequest(w3));

   sysid_regs #(.ID_VALUE(ID), .TIMESTAMP_VALUE(TS), .READ_LATENCY(4), .NUM_SCRATCH(2),
                .SCRATCH_INIT(SINIT)) u4 (
      .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
      .writedata(writedata), .readdata(rd4), .readdatavalid(v4), .waitrequest(w4));

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      logic [31:0] rdv [4];
      logic        vv [4];
      logic        ww [4];
      #1;
      rdv = '{rd1, rd2, rd3, rd4};
      vv  = '{v1, v2, v3, v4};
      ww  = '{w1, w2, w3, w4};
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (rdv[i] !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_readdata u%0d: got %h expected %h", i + 1, rdv[i], 32'h0);
         end
         n_cmp++;
         if (vv[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid u%0d: got %b expected 0", i + 1, vv[i]);
         end
         n_cmp++;
         if (ww[i] !== 1'b0) begin
            n_bad++;
            $display("FAIL waitrequest u%0d: got %b expected 0", i + 1, ww[i]);
         end
      end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_latency2;
      read = 1'b1;
      address = 3'd0;
      for (int k = 0; k < 5; k++) begin
         tick();
         read = 1'b0;
         n_cmp++;
         if (v2 !== (k == 1)) begin
            n_bad++;
            $display("FAIL lat2_valid k=%0d: got %b expected %b", k, v2, (k == 1));
         end
         n_cmp++;
         if (rd2 !== ((k == 1) ? ID : 32'h0)) begin
            n_bad++;
            $display("FAIL lat2_data k=%0d: got %h expected %h", k, rd2, (k == 1) ? ID : 32'h0);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [31:0] exp_d [7];
      logic        exp_v;
      exp_d = '{32'h0, 32'h0, ID, TS, ID, 32'h0, 32'h0};
      read = 1'b1;
      address = 3'd0;
      for (int k = 0; k < 7; k++) begin
         tick();
         if (k == 0) address = 3'd1;
         else if (k == 1) address = 3'd0;
         else read = 1'b0;
         exp_v = (k >= 2 && k <= 4);
         n_cmp++;
         if (v3 !== exp_v) begin
            n_bad++;
            $display("FAIL b2b_valid k=%0d: got %b expected %b", k, v3, exp_v);
         end
         n_cmp++;
         if (rd3 !== exp_d[k]) begin
            n_bad++;
            $display("FAIL b2b_data k=%0d: got %h expected %h", k, rd3, exp_d[k]);
         end
      end
   endtask

   task automatic test_scratch;
      write = 1'b1;
      address = 3'd4;
      writedata = 32'hA5A5_0001;
      tick();
      write = 1'b0;
      read = 1'b1;
      tick();
      n_cmp++;
      if (v1 !== 1'b1 || rd1 !== 32'hA5A5_0001) begin
         n_bad++;
         $display("FAIL scratch4_read: got v=%b d=%h expected v=1 d=%h", v1, rd1, 32'hA5A5_0001);
      end
      address = 3'd5;
      tick();
      n_cmp++;
      if (v1 !== 1'b1 || rd1 !== 32'h0) begin
         n_bad++;
         $display("FAIL scratch5_unmapped: got v=%b d=%h expected v=1 d=%h", v1, rd1, 32'h0);
      end
      address = 3'd4;
      write = 1'b1;
      writedata = 32'h1234_5678;
      tick();
      n_cmp++;
      if (v1 !== 1'b0 || rd1 !== 32'h0) begin
         n_bad++;
         $display("FAIL rdwr_collision: got v=%b d=%h expected v=0 d=%h", v1, rd1, 32'h0);
      end
      write = 1'b0;
      tick();
      n_cmp++;
      if (v1 !== 1'b1 || rd1 !== 32'h1234_5678) begin
         n_bad++;
         $display("FAIL collision_write_done: got v=%b d=%h expected v=1 d=%h", v1, rd1, 32'h1234_5678);
      end
      read = 1'b0;
      tick();
      n_cmp++;
      if (v1 !== 1'b0 || rd1 !== 32'h0) begin
         n_bad++;
         $display("FAIL scratch_idle: got v=%b d=%h expected v=0 d=%h", v1, rd1, 32'h0);
      end
   endtask

`ifdef SYSID_UPTIME_EN
   task automatic test_uptime;
      logic [2:0]  seq_a [6];
      logic        seq_r [6];
      logic        seq_w [6];
      logic        exp_v [6];
      logic [31:0] exp_d [6];
      force u1.uptime_nxt = 64'h0000_0001_FFFF_FFFF;
      read = 1'b1;
      address = 3'd2;
      tick();
      release u1.uptime_nxt;
      n_cmp++;
      if (v1 !== 1'b1 || rd1 !== 32'hFFFF_FFFF) begin
         n_bad++;
         $display("FAIL uptime_lo: got v=%b d=%h expected v=1 d=%h", v1, rd1, 32'hFFFF_FFFF);
      end
      address = 3'd3;
      tick();
      n_cmp++;
      if (v1 !== 1'b1 || rd1 !== 32'h0000_0001) begin
         n_bad++;
         $display("FAIL uptime_hi_snap: got v=%b d=%h expected v=1 d=%h", v1, rd1, 32'h0000_0001);
      end
      // clear, read LO, HI snap, CTRL, clear+read collision, read LO
      seq_a = '{3'd7, 3'd2, 3'd3, 3'd7, 3'd7, 3'd2};
      seq_r = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      seq_w = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      exp_d = '{32'h0, 32'h1, 32'h0, 32'h1, 32'h0, 32'h1};
      writedata = 32'h0000_0001;
      for (int k = 0; k < 6; k++) begin
         address = seq_a[k];
         read = seq_r[k];
         write = seq_w[k];
         tick();
         n_cmp++;
         if (v1 !== exp_v[k] || rd1 !== exp_d[k]) begin
            n_bad++;
            $display("FAIL uptime_seq k=%0d: got v=%b d=%h expected v=%b d=%h",
                     k, v1, rd1, exp_v[k], exp_d[k]);
         end
      end
      read = 1'b0;
      write = 1'b0;
   endtask
`else
   task automatic test_uptime;
      logic [2:0] addrs [3];
      addrs = '{3'd2, 3'd3, 3'd7};
      write = 1'b1;
      address = 3'd7;
      writedata = 32'h0000_0001;
      tick();
      write = 1'b0;
      read = 1'b1;
      for (int k = 0; k < 3; k++) begin
         address = addrs[k];
         tick();
         n_cmp++;
         if (v1 !== 1'b1 || rd1 !== 32'h0) begin
            n_bad++;
            $display("FAIL no_uptime_addr%0d: got v=%b d=%h expected v=1 d=%h",
                     addrs[k], v1, rd1, 32'h0);
         end
      end
      read = 1'b0;
      tick();
   endtask
`endif

   task automatic test_reset_midread;
      read = 1'b1;
      address = 3'd4;
      tick();
      read = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (v4 !== 1'b0 || rd4 !== 32'h0) begin
         n_bad++;
         $display("FAIL midread_async: got v=%b d=%h expected v=0 d=%h", v4, rd4, 32'h0);
      end
      for (int k = 0; k < 2; k++) begin
         tick();
         n_cmp++;
         if (v4 !== 1'b0) begin
            n_bad++;
            $display("FAIL midread_held k=%0d: got %b expected 0", k, v4);
         end
      end
      reset_n = 1'b1;
      tick();
      n_cmp++;
      if (v4 !== 1'b0) begin
         n_bad++;
         $display("FAIL midread_released: got %b expected 0", v4);
      end
      read = 1'b1;
      address = 3'd4;
      for (int k = 0; k < 5; k++) begin
         tick();
         read = 1'b0;
         n_cmp++;
         if (v4 !== (k == 3) || rd4 !== ((k == 3) ? SINIT : 32'h0)) begin
            n_bad++;
            $display("FAIL scratch_init k=%0d: got v=%b d=%h expected v=%b d=%h",
                     k, v4, rd4, (k == 3), (k == 3) ? SINIT : 32'h0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency2();
      test_back_to_back();
      test_scratch();
      test_uptime();
      test_reset_midread();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation did not complete");
   end

endmodule
